// File: rtl/bpsraminit.sv
// bpsraminit: write-port front end for predictor table SRAMs (PHT/BHT).
// After reset it sweeps every entry to INITVAL, then passes predictor update
// writes straight through to the SRAM write port with no added latency.
// While sweeping, read data is masked to INITVAL and InitBusyF is raised.
// Optional feature: define BPINIT_FLUSH_EN to let FlushReq re-run the sweep
// from READY (fence.i / predictor-clear CSR writes).
module bpsraminit #(
  parameter int unsigned           DEPTH   = 64,
  parameter int unsigned           WIDTH   = 2,
  parameter logic [WIDTH-1:0]      INITVAL = 'b01
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     UpdCE,
  input  logic                     UpdWE,
  input  logic [$clog2(DEPTH)-1:0] UpdAdr,
  input  logic [WIDTH-1:0]         UpdData,
  input  logic [WIDTH-1:0]         RdDataIn,
  input  logic                     FlushReq,
  output logic                     SramCE,
  output logic                     SramWE,
  output logic [$clog2(DEPTH)-1:0] SramAdr,
  output logic [WIDTH-1:0]         SramData,
  output logic [WIDTH-1:0]         RdDataOut,
  output logic                     InitBusyF
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t          state, nextState;
  logic [AW-1:0]   InitAdr, nextInitAdr;

`ifndef BPINIT_FLUSH_EN
  // FlushReq has no function without the flush feature.
  logic unusedFlushReq;
  assign unusedFlushReq = FlushReq;
`endif

  // State and sweep-address registers; reset restarts the sweep at entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      InitAdr <= '0;
    end else begin
      state   <= nextState;
      InitAdr <= nextInitAdr;
    end
  end

  // Next-state logic: step through every entry once, then hold in READY.
  always_comb begin
    nextState   = state;
    nextInitAdr = InitAdr;
    case (state)
      INIT: begin
        if (InitAdr == AW'(DEPTH - 1)) begin
          nextState   = READY;
          nextInitAdr = '0;
        end else begin
          nextInitAdr = InitAdr + AW'(1);
        end
      end
      READY: begin
`ifdef BPINIT_FLUSH_EN
        if (FlushReq) begin
          nextState   = INIT;
          nextInitAdr = '0;
        end
`endif
      end
      default: begin
        nextState   = INIT;
        nextInitAdr = '0;
      end
    endcase
  end

  // Output mux: sweep writes override the predictor during INIT; passthrough in READY.
  always_comb begin
    SramCE    = UpdCE;
    SramWE    = UpdWE;
    SramAdr   = UpdAdr;
    SramData  = UpdData;
    RdDataOut = RdDataIn;
    InitBusyF = 1'b0;
    if (state != READY) begin
      SramCE    = 1'b1;
      SramWE    = 1'b1;
      SramAdr   = InitAdr;
      SramData  = INITVAL;
      RdDataOut = INITVAL;
      InitBusyF = 1'b1;
    end
  end

endmodule

// File: tb/tb_bpsraminit.sv
// Self-checking bench for bpsraminit (DEPTH=16, WIDTH=2, INITVAL=01).
// The reference model tracks only "how many sweep writes have been issued";
// the expected SRAM port values are derived from that count each cycle.
module tb_bpsraminit;

  localparam int DEPTH = 16;
  localparam int WIDTH = 2;
  localparam int AW    = 4;
  localparam logic [1:0] IV = 2'b01;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          UpdCE = 1'b0, UpdWE = 1'b0, FlushReq = 1'b0;
  logic [AW-1:0] UpdAdr = '0;
  logic [1:0]    UpdData = '0, RdDataIn = '0;
  logic          SramCE, SramWE, InitBusyF;
  logic [AW-1:0] SramAdr;
  logic [1:0]    SramData, RdDataOut;

  int errors = 0;
  int checks = 0;
  // Number of sweep writes already completed; DEPTH means the table is ready, -1 unknown.
  int swept = -1;
  logic [10:0] expVec;
  logic [10:0] actVec;

  assign actVec = {SramCE, SramWE, SramAdr, SramData, RdDataOut, InitBusyF};

  always #5 clk = ~clk;

  bpsraminit #(.DEPTH(DEPTH), .WIDTH(WIDTH), .INITVAL(IV)) dut (
    .clk(clk), .reset(reset), .UpdCE(UpdCE), .UpdWE(UpdWE), .UpdAdr(UpdAdr),
    .UpdData(UpdData), .RdDataIn(RdDataIn), .FlushReq(FlushReq),
    .SramCE(SramCE), .SramWE(SramWE), .SramAdr(SramAdr), .SramData(SramData),
    .RdDataOut(RdDataOut), .InitBusyF(InitBusyF)
  );

  // Advance the model across a clock edge, then drive this cycle's inputs and
  // form the expected output vector.
  task automatic step(input logic r, input logic ce, input logic we,
                      input logic [AW-1:0] a, input logic [1:0] d,
                      input logic [1:0] rd, input logic fl);
    @(posedge clk);
    if (reset) swept = 0;
    else if (swept >= 0 && swept < DEPTH) swept = swept + 1;
`ifdef BPINIT_FLUSH_EN
    else if (swept == DEPTH && FlushReq) swept = 0;
`endif
    @(negedge clk);
    reset = r; UpdCE = ce; UpdWE = we; UpdAdr = a; UpdData = d;
    RdDataIn = rd; FlushReq = fl;
    #1;
    if (swept >= 0 && swept < DEPTH) expVec = {1'b1, 1'b1, 4'(swept), IV, IV, 1'b1};
    else                             expVec = {ce, we, a, d, rd, 1'b0};
  endtask

  task automatic rstep(input logic r, input logic fl);
    step(r, 1'($urandom), 1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom), fl);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b1, 4'd7, 2'b11, 2'b10, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'd9, 2'b10, 2'b11, 1'b0);
    checks++;
    if (actVec !== {1'b1, 1'b1, 4'd0, IV, IV, 1'b1}) begin
      errors++; $display("FAIL reset_state: got %b expected %b", actVec, {1'b1, 1'b1, 4'd0, IV, IV, 1'b1});
    end
  endtask

  task automatic test_sweep();
    int writes = 0;
    int fallAt = -1;
    step(1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b0);
    for (int c = 0; c < DEPTH + 4; c++) begin
      if (c == 5 || c == 15 || c == 16) step(1'b0, 1'b1, 1'b1, 4'd3, 2'b11, 2'b00, 1'b0);
      else step(1'b0, 1'b1, 1'b0, 4'($urandom), 2'($urandom), 2'($urandom), 1'b0);
      checks++;
      if (actVec !== expVec) begin
        errors++; $display("FAIL sweep_c%0d: got %b expected %b", c, actVec, expVec);
      end
      if (SramWE === 1'b1 && InitBusyF === 1'b1 && SramData === IV) writes++;
      if (fallAt < 0 && InitBusyF === 1'b0) fallAt = c;
      if (c == 5) begin
        checks++;
        if ({SramWE, SramAdr, SramData} !== {1'b1, 4'd5, IV}) begin
          errors++; $display("FAIL drop_upd_c5: got %b expected %b", {SramWE, SramAdr, SramData}, {1'b1, 4'd5, IV});
        end
      end
      if (c == 15) begin
        checks++;
        if ({SramWE, SramAdr, SramData} !== {1'b1, 4'd15, IV}) begin
          errors++; $display("FAIL drop_upd_c15: got %b expected %b", {SramWE, SramAdr, SramData}, {1'b1, 4'd15, IV});
        end
      end
      if (c == 16) begin
        checks++;
        if ({SramWE, SramAdr, SramData} !== {1'b1, 4'd3, 2'b11}) begin
          errors++; $display("FAIL pass_upd_c16: got %b expected %b", {SramWE, SramAdr, SramData}, {1'b1, 4'd3, 2'b11});
        end
      end
    end
    checks++;
    if (writes != DEPTH) begin
      errors++; $display("FAIL sweep_writes: got %0d expected %0d", writes, DEPTH);
    end
    checks++;
    if (fallAt != DEPTH) begin
      errors++; $display("FAIL busy_fall: got cycle %0d expected %0d", fallAt, DEPTH);
    end
  endtask

  task automatic test_midreset();
    int writes = 0;
    bit busyGap = 0;
    step(1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b0);
    for (int c = 0; c < 8 + DEPTH + 3; c++) begin
      rstep((c == 8) ? 1'b1 : 1'b0, 1'b0);
      checks++;
      if (actVec !== expVec) begin
        errors++; $display("FAIL midreset_c%0d: got %b expected %b", c, actVec, expVec);
      end
      if (c > 8 && SramWE === 1'b1 && InitBusyF === 1'b1) writes++;
      if (c <= 8 + DEPTH && InitBusyF !== 1'b1) busyGap = 1;
    end
    checks++;
    if (writes != DEPTH || busyGap) begin
      errors++; $display("FAIL midreset_resweep: got writes=%0d gap=%0d expected writes=%0d gap=0", writes, busyGap, DEPTH);
    end
  endtask

  task automatic test_rdmask();
    step(1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 2'b10, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b10, 1'b0);
    checks++;
    if (RdDataOut !== IV) begin
      errors++; $display("FAIL rdmask_init: got %b expected %b", RdDataOut, IV);
    end
    for (int c = 1; c <= DEPTH; c++) step(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b10, 1'b0);
    checks++;
    if (RdDataOut !== 2'b10) begin
      errors++; $display("FAIL rdmask_ready: got %b expected %b", RdDataOut, 2'b10);
    end
  endtask

  task automatic test_flush();
    int writes = 0;
    step(1'b0, 1'b1, 1'b1, 4'd6, 2'b10, 2'b11, 1'b1);
    checks++;
    if ({SramWE, SramAdr, SramData, InitBusyF} !== {1'b1, 4'd6, 2'b10, 1'b0}) begin
      errors++; $display("FAIL flush_cycle_pass: got %b expected %b", {SramWE, SramAdr, SramData, InitBusyF}, {1'b1, 4'd6, 2'b10, 1'b0});
    end
    for (int c = 0; c < DEPTH + 2; c++) begin
      rstep(1'b0, (c == 4) ? 1'b1 : 1'b0);
      checks++;
      if (actVec !== expVec) begin
        errors++; $display("FAIL flush_c%0d: got %b expected %b", c, actVec, expVec);
      end
      if (SramWE === 1'b1 && InitBusyF === 1'b1) writes++;
    end
`ifdef BPINIT_FLUSH_EN
    checks++;
    if (writes != DEPTH) begin
      errors++; $display("FAIL flush_resweep: got %0d writes expected %0d", writes, DEPTH);
    end
`else
    checks++;
    if (writes != 0) begin
      errors++; $display("FAIL flush_ignored: got %0d writes expected 0", writes);
    end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rstep(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
      checks++;
      if (actVec !== expVec) begin
        errors++; $display("FAIL random_c%0d: got %b expected %b swept=%0d", c, actVec, expVec, swept);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_midreset();
    test_rdmask();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
